// File: rtl/bcd_wallet_arbiter.sv
// Round-robin arbiter sharing one six-digit BCD add/subtract accumulator among
// NUM_REQ requesters; validates each amount before issuing a one-cycle enable.
module bcd_wallet_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ-1:0]     reqSub,
  input  logic [0:NUM_REQ*24-1]  reqAmount,
  input  logic [0:23]            accResult,
  output logic                   accEnableAdd,
  output logic                   accEnableSub,
  output logic [0:23]            accAmount,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     nack,
  output logic                   busy,
  output logic [IDX_W-1:0]       grantIdx
);

  localparam int unsigned NR = NUM_REQ;

  typedef enum logic [1:0] {IDLE, CHECK, APPLY, DONE} state_t;

  state_t               state_q;
  logic [IDX_W-1:0]     rr_ptr_q, grant_q;
  logic [0:23]          amt_q, acc_amt_q;
  logic                 sub_q, en_add_q, en_sub_q;
  logic [NUM_REQ-1:0]   served_q, served_d, eligible, ack_q, nack_q;
  logic                 pick_valid, reject;
  logic [IDX_W-1:0]     pick_idx;
  int unsigned          k;

  // Digit 5 is placed in the top nibble so a plain unsigned compare is digit-wise.
  function automatic logic [23:0] to_num(input logic [0:23] v);
    logic [23:0] n;
    n = '0;
    for (int unsigned i = 0; i < 6; i++) n[4*i +: 4] = v[4*i +: 4];
    return n;
  endfunction

  function automatic logic [0:23] nines(input logic [0:23] v);
    logic [0:23] r;
    r = '0;
    for (int unsigned i = 0; i < 6; i++) r[4*i +: 4] = 4'd9 - v[4*i +: 4];
    return r;
  endfunction

  function automatic logic bcd_ok(input logic [0:23] v);
    logic ok;
    ok = 1'b1;
    for (int unsigned i = 0; i < 6; i++) if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  assign eligible = req & ~served_q;
  // A requester stays served until it drops req, so a held request is served once.
  assign served_d = req & (served_q | ack_q | nack_q);

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    k          = 0;
    for (int unsigned off = 0; off < NR; off++) begin
      k = 32'(rr_ptr_q) + off;
      if (k >= NR) k = k - NR;
      if (!pick_valid && eligible[k]) begin
        pick_valid = 1'b1;
        pick_idx   = IDX_W'(k);
      end
    end
  end

  always_comb begin
    reject = !bcd_ok(amt_q);
    if (sub_q) begin
      if (to_num(amt_q) > to_num(accResult)) reject = 1'b1;
    end else begin
      if (to_num(amt_q) > to_num(nines(accResult))) reject = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      amt_q     <= '0;
      sub_q     <= 1'b0;
      served_q  <= '0;
      en_add_q  <= 1'b0;
      en_sub_q  <= 1'b0;
      acc_amt_q <= '0;
      ack_q     <= '0;
      nack_q    <= '0;
    end else begin
      en_add_q  <= 1'b0;
      en_sub_q  <= 1'b0;
      acc_amt_q <= '0;
      ack_q     <= '0;
      nack_q    <= '0;
      served_q  <= served_d;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q <= pick_idx;
            amt_q   <= reqAmount[24*pick_idx +: 24];
            sub_q   <= reqSub[pick_idx];
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (reject) begin
            nack_q[grant_q] <= 1'b1;
            state_q         <= DONE;
          end else begin
            en_add_q  <= !sub_q;
            en_sub_q  <= sub_q;
            acc_amt_q <= amt_q;
            state_q   <= APPLY;
          end
        end
        APPLY: begin
          ack_q[grant_q] <= 1'b1;
          state_q        <= DONE;
        end
        DONE: begin
          rr_ptr_q <= (grant_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_q + 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign accEnableAdd = en_add_q;
  assign accEnableSub = en_sub_q;
  assign accAmount    = acc_amt_q;
  assign ack          = ack_q;
  assign nack         = nack_q;
  assign busy         = (state_q != IDLE);
  assign grantIdx     = grant_q;

endmodule

// File: tb/tb_bcd_wallet_arbiter.sv
// Directed bench for bcd_wallet_arbiter with a behavioural BCD accumulator
// on the result bus; expected values are hand-computed constants.
module tb_bcd_wallet_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  logic                  clk = 1'b0;
  logic                  resetN;
  logic [NUM_REQ-1:0]    req, req_sub;
  logic [0:NUM_REQ*24-1] req_amount;
  logic [0:23]           bal;
  logic                  en_add, en_sub;
  logic [0:23]           acc_amount;
  logic [NUM_REQ-1:0]    ack, nack;
  logic                  busy;
  logic [IDX_W-1:0]      grant_idx;

  int n_checks = 0;
  int n_err    = 0;

  bcd_wallet_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
    .clk(clk), .resetN(resetN), .req(req), .reqSub(req_sub),
    .reqAmount(req_amount), .accResult(bal),
    .accEnableAdd(en_add), .accEnableSub(en_sub), .accAmount(acc_amount),
    .ack(ack), .nack(nack), .busy(busy), .grantIdx(grant_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [0:23] bcd(input int unsigned n);
    logic [0:23] v;
    int unsigned x;
    v = '0;
    x = n;
    for (int unsigned i = 0; i < 6; i++) begin
      v[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return v;
  endfunction

  function automatic int unsigned dec(input logic [0:23] v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 6; i > 0; i--) r = r * 10 + 32'(v[4*(i-1) +: 4]);
    return r;
  endfunction

  // Behavioural accumulator sharing resetN with the arbiter.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) bal <= '0;
    else if (en_add) bal <= bcd((dec(bal) + dec(acc_amount)) % 1000000);
    else if (en_sub) bal <= bcd((dec(bal) + 1000000 - dec(acc_amount)) % 1000000);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("en_excl", {31'd0, en_add & en_sub}, 32'd0);
    chk("resp_onehot", {31'd0, $countones(ack | nack) > 1}, 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts just after an edge with the arbiter idle; ends with it idle again.
  task automatic do_txn(input int k, input logic sub, input logic [0:23] amt,
                        input logic accept, input logic [0:23] exp_bal);
    logic [NUM_REQ-1:0] one;
    one = '0;
    one[k] = 1'b1;
    req_amount[k*24 +: 24] = amt;
    req_sub[k] = sub;
    req[k] = 1'b1;
    tick();
    chk("busy_check", {31'd0, busy}, 32'd1);
    chk("grant", {30'd0, grant_idx}, k);
    chk("amt_zero_check", {8'd0, acc_amount}, 32'd0);
    tick();
    if (accept) begin
      chk("en_add", {31'd0, en_add}, {31'd0, !sub});
      chk("en_sub", {31'd0, en_sub}, {31'd0, sub});
      chk("acc_amount", {8'd0, acc_amount}, {8'd0, amt});
      chk("no_early_ack", {28'd0, ack | nack}, 32'd0);
      tick();
      chk("ack", {28'd0, ack}, {28'd0, one});
      chk("nack_idle", {28'd0, nack}, 32'd0);
      chk("balance", {8'd0, bal}, {8'd0, exp_bal});
      chk("amt_zero_done", {8'd0, acc_amount}, 32'd0);
    end else begin
      chk("nack", {28'd0, nack}, {28'd0, one});
      chk("ack_idle", {28'd0, ack}, 32'd0);
      chk("no_enable", {30'd0, en_add, en_sub}, 32'd0);
    end
    req[k] = 1'b0;
    tick();
    chk("idle_after", {31'd0, busy}, 32'd0);
    chk("balance_after", {8'd0, bal}, {8'd0, exp_bal});
  endtask

  initial begin
    logic [0:23] bad;
    resetN = 1'b0;
    req = '0;
    req_sub = '0;
    req_amount = '0;
    tick();
    tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_grant", {30'd0, grant_idx}, 32'd0);
    chk("rst_enables", {30'd0, en_add, en_sub}, 32'd0);
    chk("rst_amount", {8'd0, acc_amount}, 32'd0);
    chk("rst_resp", {24'd0, ack, nack}, 32'd0);
    resetN = 1'b1;
    tick();

    do_txn(0, 1'b0, bcd(150), 1'b1, bcd(150));
    do_txn(1, 1'b1, bcd(200), 1'b0, bcd(150));
    do_txn(1, 1'b1, bcd(150), 1'b1, bcd(0));
    do_txn(2, 1'b0, bcd(0), 1'b1, bcd(0));
    do_txn(2, 1'b0, bcd(999990), 1'b1, bcd(999990));
    do_txn(0, 1'b0, bcd(9), 1'b1, bcd(999999));
    do_txn(1, 1'b0, bcd(1), 1'b0, bcd(999999));
    bad = bcd(0);
    bad[0:3] = 4'hA;
    do_txn(3, 1'b1, bad, 1'b0, bcd(999999));

    // Round-robin from a fresh reset: rrPtr=0, balance 0.
    resetN = 1'b0;
    #2;
    resetN = 1'b1;
    tick();
    for (int i = 0; i < NUM_REQ; i++) req_amount[i*24 +: 24] = bcd(1);
    req_sub = '0;
    req = '1;
    tick();
    for (int i = 0; i < NUM_REQ; i++) begin
      chk("rr_grant", {30'd0, grant_idx}, i);
      tick();
      tick();
      chk("rr_ack", {28'd0, ack}, 32'd1 << i);
      chk("rr_bal", dec(bal), i + 1);
      tick();
      tick();
    end
    chk("rr_no_regrant_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    chk("rr_no_regrant_busy2", {31'd0, busy}, 32'd0);
    chk("rr_no_regrant_resp", {24'd0, ack, nack}, 32'd0);
    req[0] = 1'b0;
    tick();
    req[0] = 1'b1;
    tick();
    chk("rr_regrant", {30'd0, grant_idx}, 32'd0);
    tick();
    tick();
    chk("rr_reack", {28'd0, ack}, 32'd1);
    chk("rr_final_bal", {8'd0, bal}, {8'd0, bcd(5)});
    req = '0;
    tick();
    tick();

    // Reset during APPLY aborts the transaction.
    req_amount[1*24 +: 24] = bcd(5);
    req[1] = 1'b1;
    tick();
    tick();
    chk("mid_en_add", {31'd0, en_add}, 32'd1);
    #2;
    resetN = 1'b0;
    #1;
    chk("mid_rst_enables", {30'd0, en_add, en_sub}, 32'd0);
    chk("mid_rst_amount", {8'd0, acc_amount}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_grant", {30'd0, grant_idx}, 32'd0);
    req = '0;
    tick();
    resetN = 1'b1;
    tick();
    tick();
    chk("post_rst_resp", {24'd0, ack, nack}, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_bal", {8'd0, bal}, 32'd0);
    req_amount[0*24 +: 24] = bcd(2);
    req_amount[1*24 +: 24] = bcd(3);
    req = 4'b0011;
    tick();
    chk("post_rst_rrptr", {30'd0, grant_idx}, 32'd0);
    tick();
    tick();
    chk("post_rst_ack", {28'd0, ack}, 32'd1);
    chk("post_rst_bal2", {8'd0, bal}, {8'd0, bcd(2)});
    req = '0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/bcd_wallet_arbiter.md
Name: bcd_wallet_arbiter

Overview:
- Round-robin controller that shares one six-digit BCD add/subtract accumulator among NUM_REQ requesters (pickups, purchases, penalties).
- Validates each transaction before applying it: BCD legality of the amount, underflow on subtract, overflow past 999999 on add.
- Issues exactly one single-cycle enable per accepted transaction and returns ack or nack to the requester.
- Sits between game-logic requesters and the accumulator; reads the accumulator's result bus back as the current balance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, $clog2(NUM_REQ), width of requester index.

Ports:
- clk  in  1  clock.
- resetN  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  level request per requester; held until ack or nack.
- reqSub  in  NUM_REQ  1 = subtract, 0 = add; stable while req is high.
- reqAmount  in  NUM_REQ*24  packed BCD amounts; requester k uses bits [k*24 +: 24], internally ordered [0:23].
- accResult  in  24 [0:23]  accumulator balance.
- accEnableAdd  out  1  one-cycle add strobe to the accumulator.
- accEnableSub  out  1  one-cycle subtract strobe.
- accAmount  out  24 [0:23]  amount presented to the accumulator.
- ack  out  NUM_REQ  one-cycle pulse, transaction applied.
- nack  out  NUM_REQ  one-cycle pulse, transaction rejected.
- busy  out  1  high in any state other than IDLE.
- grantIdx  out  IDX_W  requester currently being served.

Behaviour:
- Digit format: a 24-bit value is six 4-bit digits. Digit i occupies bits [4i:4i+3] of the [0:23] vector. Digit 0 is least significant and digit 5 is most significant. All magnitude compares go digit-wise from digit 5 down to digit 0.
- Reset: state IDLE, rrPtr=0, served mask=0, grantIdx=0, amount latch=0, all outputs 0. Reset mid-transaction aborts it with no enable and no ack/nack. The accumulator shares resetN.
- Eligibility: requester k is eligible when req[k]=1 and served[k]=0.
- served[k] is set when ack[k] or nack[k] pulses, and cleared in any cycle where req[k]=0. A held req is therefore never served twice.
- IDLE: if any requester is eligible, grant the first eligible index at or after rrPtr, wrapping modulo NUM_REQ. Latch its index, amount and op, then go to CHECK.
- CHECK (1 cycle): reject if any amount digit > 9, if Sub and amount > accResult, or if Add and amount > nines-complement(accResult), i.e. per digit 9-d. Accept goes to APPLY; reject goes to DONE with nack.
- APPLY (1 cycle): accAmount = latched amount; exactly one of accEnableAdd or accEnableSub = 1. The accumulator updates on this cycle's closing edge. Go to DONE.
- DONE (1 cycle): pulse ack[grantIdx] or nack[grantIdx], set rrPtr = grantIdx+1 mod NUM_REQ, go to IDLE.
- accAmount is 0 outside APPLY.
- Latency, request seen in IDLE at cycle 0:
  - accept: enable at cycle 2, ack at cycle 3, new balance visible at cycle 3;
  - reject: nack at cycle 2, no enable;
  - next grant possible at cycle 4 (accept) or cycle 3 (reject).
- Amount 000000 is accepted; an enable is still issued and the balance is unchanged.
- Requests arriving while busy wait; there is no queueing beyond the req level.
- Dropping req mid-transaction does not abort it; ack/nack still pulses.
- accEnableAdd and accEnableSub are never high together.
- At most one bit across ack|nack is high in any cycle.

Test Plan:
- Single add, balance 000000, req0 add 000150 -> accEnableAdd at cycle 2 with accAmount=000150; ack[0] at cycle 3; accResult=000150.
- Underflow: balance 000150, req1 sub 000200 -> nack[1] at cycle 2; no enable; balance stays 000150. Then sub 000150 -> ack; balance 000000.
- Overflow boundary: balance 999990, add 000009 -> ack, balance 999999. Then add 000001 -> nack, balance unchanged.
- Illegal BCD: amount with a digit of 4'hA -> nack; no enable pulse.
- Round-robin: req0..req3 all held high with add 000001 -> grants in order 0,1,2,3. No re-grant while reqs stay high. Drop and re-raise req0 -> it is served once more. Final balance 000005.
- Reset mid-op: assert resetN=0 during APPLY -> all outputs 0 immediately. After release: IDLE, rrPtr=0, no stray ack.
